// File: rtl/apb3_arb_pkg.sv
// Shared state encoding, master indices and GRANT encodings for the
// two-master APB3 arbiter.
package apb3_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam int M0_IDX = 0;
  localparam int M1_IDX = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/apb3_master_arbiter_if.sv
// Bundle of the two upstream APB3 slave ports, the downstream APB3 master
// port and the GRANT observability bus.
interface apb3_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL_M0, PENABLE_M0, PWRITE_M0;
  logic [ADDR_WIDTH-1:0] PADDR_M0;
  logic [DATA_WIDTH-1:0] PWDATA_M0, PRDATA_M0;
  logic                  PREADY_M0, PSLVERR_M0;

  logic                  PSEL_M1, PENABLE_M1, PWRITE_M1;
  logic [ADDR_WIDTH-1:0] PADDR_M1;
  logic [DATA_WIDTH-1:0] PWDATA_M1, PRDATA_M1;
  logic                  PREADY_M1, PSLVERR_M1;

  logic                  PSEL, PENABLE, PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA, PRDATA;
  logic                  PREADY, PSLVERR;
  logic [1:0]            GRANT;

  // Arbiter side.
  modport slave (
    input  PSEL_M0, PENABLE_M0, PWRITE_M0, PADDR_M0, PWDATA_M0,
    output PRDATA_M0, PREADY_M0, PSLVERR_M0,
    input  PSEL_M1, PENABLE_M1, PWRITE_M1, PADDR_M1, PWDATA_M1,
    output PRDATA_M1, PREADY_M1, PSLVERR_M1,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, GRANT,
    input  PRDATA, PREADY, PSLVERR
  );

  // Environment side: upstream masters and downstream slave.
  modport master (
    output PSEL_M0, PENABLE_M0, PWRITE_M0, PADDR_M0, PWDATA_M0,
    input  PRDATA_M0, PREADY_M0, PSLVERR_M0,
    output PSEL_M1, PENABLE_M1, PWRITE_M1, PADDR_M1, PWDATA_M1,
    input  PRDATA_M1, PREADY_M1, PSLVERR_M1,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, GRANT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_access_watchdog.sv
// Counts stalled ACCESS cycles; o_expired marks the last cycle a slave may
// hold PREADY low before the arbiter aborts. Tied off when TIMEOUT_CYCLES=0.
module apb3_access_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdt
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] r_count;

      // Saturates at LIMIT so a stuck slave never wraps the counter.
      always_ff @(posedge PCLK) begin
        if (!PRESETN || i_clear) begin
          r_count <= '0;
        end else if (i_count_en && (r_count != LIMIT)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign o_expired = (r_count == LIMIT);
    end else begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, PCLK, PRESETN, i_clear, i_count_en};
      assign o_expired = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/apb3_master_arbiter.sv
// Two-master APB3 arbiter: serialises M0/M1 transfers onto one downstream
// APB3 port and returns the response to the granted master only.
module apb3_master_arbiter
  import apb3_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  apb3_master_arbiter_if.slave bus
);
  arb_state_e            r_state, w_state_next;
  logic                  r_ptr, w_ptr_next;
  logic [1:0]            r_grant, w_grant_next;
  logic                  r_psel, w_psel_next;
  logic                  r_penable, w_penable_next;
  logic                  r_pwrite, w_pwrite_next;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_next;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_next;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_next;
  logic                  r_err, w_err_next;
  logic                  w_pick_m1, w_any_req, w_resp;
  logic                  w_wdt_clear, w_wdt_en, w_wdt_expired;
  logic                  w_unused_penable;

  assign w_unused_penable = bus.PENABLE_M0 ^ bus.PENABLE_M1;
  assign w_any_req        = bus.PSEL_M0 | bus.PSEL_M1;
  // r_ptr=1 means M1 is preferred on a tie (round robin only).
  assign w_pick_m1 = bus.PSEL_M1 & (~bus.PSEL_M0 | ((FIXED_PRIO == 0) & r_ptr));

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_grant_next   = r_grant;
    w_psel_next    = r_psel;
    w_penable_next = r_penable;
    w_pwrite_next  = r_pwrite;
    w_paddr_next   = r_paddr;
    w_pwdata_next  = r_pwdata;
    w_rdata_next   = r_rdata;
    w_err_next     = r_err;
    w_wdt_clear    = 1'b0;
    w_wdt_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next   = ST_SETUP;
          w_grant_next   = w_pick_m1 ? GRANT_M1 : GRANT_M0;
          w_paddr_next   = w_pick_m1 ? bus.PADDR_M1  : bus.PADDR_M0;
          w_pwdata_next  = w_pick_m1 ? bus.PWDATA_M1 : bus.PWDATA_M0;
          w_pwrite_next  = w_pick_m1 ? bus.PWRITE_M1 : bus.PWRITE_M0;
          w_psel_next    = 1'b1;
          w_penable_next = 1'b0;
          w_wdt_clear    = 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_next   = ST_ACCESS;
        w_penable_next = 1'b1;
      end
      ST_ACCESS: begin
        w_wdt_en = ~bus.PREADY;
        if (bus.PREADY) begin
          w_state_next   = ST_RESP;
          w_rdata_next   = bus.PRDATA;
          w_err_next     = bus.PSLVERR;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
        end else if (w_wdt_expired) begin
          w_state_next   = ST_RESP;
          w_rdata_next   = '0;
          w_err_next     = 1'b1;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
        w_grant_next = GRANT_NONE;
        if (FIXED_PRIO == 0) begin
          w_ptr_next = r_grant[M0_IDX];
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 1'b0;
      r_grant   <= GRANT_NONE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_grant   <= w_grant_next;
      r_psel    <= w_psel_next;
      r_penable <= w_penable_next;
      r_pwrite  <= w_pwrite_next;
      r_paddr   <= w_paddr_next;
      r_pwdata  <= w_pwdata_next;
      r_rdata   <= w_rdata_next;
      r_err     <= w_err_next;
    end
  end

  apb3_access_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .i_clear    (w_wdt_clear),
    .i_count_en (w_wdt_en),
    .o_expired  (w_wdt_expired)
  );

  assign w_resp         = (r_state == ST_RESP);
  assign bus.PSEL       = r_psel;
  assign bus.PENABLE    = r_penable;
  assign bus.PWRITE     = r_pwrite;
  assign bus.PADDR      = r_paddr;
  assign bus.PWDATA     = r_pwdata;
  assign bus.GRANT      = r_grant;
  assign bus.PRDATA_M0  = r_rdata;
  assign bus.PRDATA_M1  = r_rdata;
  assign bus.PREADY_M0  = w_resp & r_grant[M0_IDX];
  assign bus.PREADY_M1  = w_resp & r_grant[M1_IDX];
  assign bus.PSLVERR_M0 = w_resp & r_grant[M0_IDX] & r_err;
  assign bus.PSLVERR_M1 = w_resp & r_grant[M1_IDX] & r_err;
endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Self-checking bench: directed vector table, randomized rounds against a
// transaction-level model, reset-abort and fixed-priority sequences.
`timescale 1ns/1ps
module tb_apb3_master_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, rstn_fp;
  logic [1:0]    psel_m, penable_m, pwrite_m;
  logic [AW-1:0] paddr_m [2];
  logic [DW-1:0] pwdata_m [2];
  logic          s_pready, s_pslverr;
  logic [DW-1:0] s_prdata;

  apb3_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
  apb3_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();

  assign bus_rr.PSEL_M0 = psel_m[0];     assign bus_fp.PSEL_M0 = psel_m[0];
  assign bus_rr.PSEL_M1 = psel_m[1];     assign bus_fp.PSEL_M1 = psel_m[1];
  assign bus_rr.PENABLE_M0 = penable_m[0]; assign bus_fp.PENABLE_M0 = penable_m[0];
  assign bus_rr.PENABLE_M1 = penable_m[1]; assign bus_fp.PENABLE_M1 = penable_m[1];
  assign bus_rr.PWRITE_M0 = pwrite_m[0]; assign bus_fp.PWRITE_M0 = pwrite_m[0];
  assign bus_rr.PWRITE_M1 = pwrite_m[1]; assign bus_fp.PWRITE_M1 = pwrite_m[1];
  assign bus_rr.PADDR_M0 = paddr_m[0];   assign bus_fp.PADDR_M0 = paddr_m[0];
  assign bus_rr.PADDR_M1 = paddr_m[1];   assign bus_fp.PADDR_M1 = paddr_m[1];
  assign bus_rr.PWDATA_M0 = pwdata_m[0]; assign bus_fp.PWDATA_M0 = pwdata_m[0];
  assign bus_rr.PWDATA_M1 = pwdata_m[1]; assign bus_fp.PWDATA_M1 = pwdata_m[1];
  assign bus_rr.PREADY = s_pready;       assign bus_fp.PREADY = s_pready;
  assign bus_rr.PSLVERR = s_pslverr;     assign bus_fp.PSLVERR = s_pslverr;
  assign bus_rr.PRDATA = s_prdata;       assign bus_fp.PRDATA = s_prdata;

  apb3_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(TMO))
    u_rr (.PCLK(clk), .PRESETN(rstn), .bus(bus_rr));
  apb3_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(256))
    u_fp (.PCLK(clk), .PRESETN(rstn_fp), .bus(bus_fp));

  logic [1:0] rr_pready, rr_pslverr, fp_pready;
  assign rr_pready  = {bus_rr.PREADY_M1, bus_rr.PREADY_M0};
  assign rr_pslverr = {bus_rr.PSLVERR_M1, bus_rr.PSLVERR_M0};
  assign fp_pready  = {bus_fp.PREADY_M1, bus_fp.PREADY_M0};

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  int ptr    = 0;   // model: master preferred on a tie
  bit pend [2];     // model: master is waiting for its response

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (txn %0d)", nm, act, exp, txn);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"},    {63'd0, bus_rr.PSEL},    64'd0);
    chk({tag, "_penable"}, {63'd0, bus_rr.PENABLE}, 64'd0);
    chk({tag, "_pwrite"},  {63'd0, bus_rr.PWRITE},  64'd0);
    chk({tag, "_paddr"},   {32'd0, bus_rr.PADDR},   64'd0);
    chk({tag, "_pwdata"},  {32'd0, bus_rr.PWDATA},  64'd0);
    chk({tag, "_pready"},  {62'd0, rr_pready},      64'd0);
    chk({tag, "_pslverr"}, {62'd0, rr_pslverr},     64'd0);
    chk({tag, "_prdata0"}, {32'd0, bus_rr.PRDATA_M0}, 64'd0);
    chk({tag, "_prdata1"}, {32'd0, bus_rr.PRDATA_M1}, 64'd0);
    chk({tag, "_grant"},   {62'd0, bus_rr.GRANT},   64'd0);
  endtask

  // One arbitrated transfer, entered at the negedge of an IDLE cycle.
  task automatic do_round(input bit n0, input bit n1,
                          input logic [AW-1:0] a0, input logic [DW-1:0] d0, input bit w0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit w1,
                          input int waits, input bit serr, input logic [DW-1:0] sdata,
                          input int win, input bit eerr, input logic [DW-1:0] edata);
    logic [1:0] oh;
    if (n0) begin psel_m[0] = 1'b1; penable_m[0] = 1'b0; paddr_m[0] = a0; pwdata_m[0] = d0; pwrite_m[0] = w0; pend[0] = 1'b1; end
    if (n1) begin psel_m[1] = 1'b1; penable_m[1] = 1'b0; paddr_m[1] = a1; pwdata_m[1] = d1; pwrite_m[1] = w1; pend[1] = 1'b1; end
    oh = (win == 1) ? 2'b10 : 2'b01;
    @(negedge clk);  // SETUP
    chk("setup_grant",   {62'd0, bus_rr.GRANT}, {62'd0, oh});
    chk("setup_psel",    {62'd0, bus_rr.PSEL, bus_rr.PENABLE}, 64'd2);
    chk("setup_paddr",   {32'd0, bus_rr.PADDR},  {32'd0, paddr_m[win]});
    chk("setup_pwdata",  {32'd0, bus_rr.PWDATA}, {32'd0, pwdata_m[win]});
    chk("setup_pwrite",  {63'd0, bus_rr.PWRITE}, {63'd0, pwrite_m[win]});
    penable_m = psel_m;
    @(negedge clk);  // first ACCESS cycle
    for (int k = 0; k < TMO; k++) begin
      chk("access_psel_penable", {62'd0, bus_rr.PSEL, bus_rr.PENABLE}, 64'd3);
      chk("access_no_pready", {62'd0, rr_pready}, 64'd0);
      if (k == 0) chk("access_paddr", {32'd0, bus_rr.PADDR}, {32'd0, paddr_m[win]});
      s_pready  = (k == waits);
      s_pslverr = serr & (k == waits);
      s_prdata  = (k == waits) ? sdata : DW'($urandom);
      @(negedge clk);
      if (k == waits) break;
    end
    s_pready = 1'b0; s_pslverr = 1'b0;
    // RESP
    chk("resp_psel_drop", {62'd0, bus_rr.PSEL, bus_rr.PENABLE}, 64'd0);
    chk("resp_pready",   {62'd0, rr_pready},  {62'd0, oh});
    chk("resp_pslverr",  {62'd0, rr_pslverr}, {62'd0, eerr ? oh : 2'b00});
    chk("resp_prdata0",  {32'd0, bus_rr.PRDATA_M0}, {32'd0, edata});
    chk("resp_prdata1",  {32'd0, bus_rr.PRDATA_M1}, {32'd0, edata});
    chk("resp_grant",    {62'd0, bus_rr.GRANT}, {62'd0, oh});
    psel_m[win] = 1'b0; penable_m[win] = 1'b0; pend[win] = 1'b0;
    @(negedge clk);  // IDLE
    chk("idle_grant",   {62'd0, bus_rr.GRANT}, 64'd0);
    chk("idle_pready",  {62'd0, rr_pready, rr_pslverr} , 64'd0);
    chk("idle_prdata_hold", {32'd0, bus_rr.PRDATA_M0}, {32'd0, edata});
    ptr = 1 - win;
    $display("TXN %0d win=M%0d addr=%08h wr=%0d waits=%0d err=%0d data=%08h",
             txn, win, paddr_m[win], pwrite_m[win], waits, eerr, edata);
    txn++;
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return ptr;
    return r1 ? 1 : 0;
  endfunction

  typedef struct {
    bit n0; bit n1;
    logic [AW-1:0] a0; logic [DW-1:0] d0; bit w0;
    logic [AW-1:0] a1; logic [DW-1:0] d1; bit w1;
    int waits; bit serr; logic [DW-1:0] sdata;
    int win; bit eerr; logic [DW-1:0] edata;
  } vec_t;
  vec_t vt [11];

  initial begin
    rstn = 1'b0; rstn_fp = 1'b0;
    psel_m = '0; penable_m = '0; pwrite_m = '0;
    paddr_m[0] = '0; paddr_m[1] = '0; pwdata_m[0] = '0; pwdata_m[1] = '0;
    s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Directed table, starting from reset (tie preference M0).
    vt[0]  = '{1'b1, 1'b1, 32'h1000_0010, 32'h0, 1'b0, 32'h2000_0020, 32'h0, 1'b0, 0, 1'b0, 32'h0000_1111, 0, 1'b0, 32'h0000_1111};
    vt[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0000_2222, 1, 1'b0, 32'h0000_2222};
    vt[2]  = '{1'b1, 1'b0, 32'h7000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 0, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h2000_0100, 32'h0, 1'b0, 3, 1'b0, 32'hCAFE_0001, 1, 1'b0, 32'hCAFE_0001};
    vt[4]  = '{1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 32'h0000_0055, 0, 1'b1, 32'h0000_0055};
    vt[5]  = '{1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h4000_0000, 32'h1234_5678, 1'b1, 12, 1'b0, 32'h9999_9999, 1, 1'b1, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h5000_0000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0000_A5A5, 0, 1'b0, 32'h0000_A5A5};
    vt[7]  = '{1'b1, 1'b1, 32'h5000_0008, 32'h0, 1'b0, 32'h6000_0008, 32'h0, 1'b0, 0, 1'b0, 32'h0000_3333, 1, 1'b0, 32'h0000_3333};
    vt[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0000_4444, 0, 1'b0, 32'h0000_4444};
    vt[9]  = '{1'b1, 1'b1, 32'h5000_000C, 32'h0, 1'b0, 32'h6000_000C, 32'h0, 1'b0, 1, 1'b0, 32'h0000_5555, 1, 1'b0, 32'h0000_5555};
    vt[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 7, 1'b0, 32'h0000_6666, 0, 1'b0, 32'h0000_6666};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_round(vt[i].n0, vt[i].n1, vt[i].a0, vt[i].d0, vt[i].w0, vt[i].a1, vt[i].d1, vt[i].w1,
               vt[i].waits, vt[i].serr, vt[i].sdata, vt[i].win, vt[i].eerr, vt[i].edata);
      chk("table_model_ptr", 64'(ptr), 64'(1 - vt[i].win));
    end

    // Randomized rounds against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      bit n0, n1, serr, r0, r1;
      int waits, win;
      logic [DW-1:0] sdata;
      n0 = !pend[0] && ($urandom_range(0, 1) == 1);
      n1 = !pend[1] && ($urandom_range(0, 1) == 1);
      if (!pend[0] && !pend[1] && !n0 && !n1) n0 = 1'b1;
      r0 = pend[0] | n0; r1 = pend[1] | n1;
      win   = pick(r0, r1);
      waits = $urandom_range(0, 9);
      serr  = ($urandom_range(0, 3) == 0);
      sdata = DW'($urandom);
      do_round(n0, n1, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
               AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
               waits, serr, sdata, win,
               (waits >= TMO) ? 1'b1 : serr, (waits >= TMO) ? '0 : sdata);
    end
    while (pend[0] || pend[1]) begin
      int win;
      win = pick(pend[0], pend[1]);
      do_round(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 0, 1'b0, 32'h0BAD_F00D, win, 1'b0, 32'h0BAD_F00D);
    end

    // Leave the tie preference on M1, then reset in the middle of an ACCESS.
    do_round(1'b1, 1'b0, 32'h7000_0010, 32'h0, 1'b0, '0, '0, 1'b0, 0, 1'b0, 32'h0000_7777, 0, 1'b0, 32'h0000_7777);
    psel_m[1] = 1'b1; paddr_m[1] = 32'h8000_0040; pwdata_m[1] = 32'hFEED_FACE; pwrite_m[1] = 1'b1;
    @(negedge clk); penable_m[1] = 1'b1;
    @(negedge clk);
    chk("rst_pre_access", {62'd0, bus_rr.PSEL, bus_rr.PENABLE}, 64'd3);
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_abort");
    rstn = 1'b1; psel_m = '0; penable_m = '0;
    pend[0] = 1'b0; pend[1] = 1'b0; ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_pulse", {60'd0, rr_pready, bus_rr.GRANT}, 64'd0);
    end
    do_round(1'b1, 1'b1, 32'h1100_0000, 32'h0, 1'b0, 32'h2200_0000, 32'h0, 1'b0, 0, 1'b0, 32'h0000_AAAA, 0, 1'b0, 32'h0000_AAAA);
    do_round(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2, 1'b0, 32'h0000_BBBB, 1, 1'b0, 32'h0000_BBBB);
    do_round(1'b0, 1'b1, '0, '0, 1'b0, 32'h2200_0004, 32'h0, 1'b0, 0, 1'b0, 32'h0000_CCCC, 1, 1'b0, 32'h0000_CCCC);

    // Fixed priority: both masters request continuously, M0 must win every time.
    rstn = 1'b0; rstn_fp = 1'b1;
    psel_m = 2'b11; penable_m = 2'b00;
    paddr_m[0] = 32'hA000_0000; paddr_m[1] = 32'hB000_0000;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("fp_grant", {62'd0, bus_fp.GRANT}, 64'd1);
      chk("fp_paddr", {32'd0, bus_fp.PADDR}, {32'd0, paddr_m[0]});
      penable_m = 2'b11;
      @(negedge clk);
      s_pready = 1'b1; s_prdata = DW'(t + 16);
      @(negedge clk);
      s_pready = 1'b0;
      chk("fp_pready", {62'd0, fp_pready}, 64'd1);
      chk("fp_prdata", {32'd0, bus_fp.PRDATA_M0}, 64'(t + 16));
      penable_m[0] = 1'b0;
      @(negedge clk);
      chk("fp_idle_grant", {62'd0, bus_fp.GRANT}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
